sat_kinematic_integrator: RTL and testbench
===========================================

Name: sat_kinematic_integrator

Overview:
- Parametrised saturating signed integrator for projectile physics.
- On each step request it runs SUBSTEPS iterations of: vel <= sat(vel ± acc), then pos <= sat(pos + vel).
- Every add saturates to the signed WIDTH range; sticky flags record any clamp.
- Sits between the game-tick controller and the bird/object position registers, one instance per axis.

Parameters:
- WIDTH, 17, signed two's-complement width of pos/vel/acc.
- SUBSTEPS, 1, iterations per step request (>=1).
- CNT_W, $clog2(SUBSTEPS+1), substep counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- load_i  in  1  load pos_init_i/vel_init_i into state
- pos_init_i  in  WIDTH  initial position (signed)
- vel_init_i  in  WIDTH  initial velocity (signed)
- step_i  in  1  request one integration step (SUBSTEPS iterations)
- acc_i  in  WIDTH  acceleration (signed), latched at step accept
- sub_i  in  1  0: vel+acc, 1: vel-acc; latched at step accept
- clr_flags_i  in  1  clear sticky saturation flags
- pos_o  out  WIDTH  current position register
- vel_o  out  WIDTH  current velocity register
- busy_o  out  1  high while state != IDLE
- done_o  out  1  one-cycle pulse after final position update
- sat_pos_o  out  1  sticky: a position add clamped
- sat_vel_o  out  1  sticky: a velocity add clamped

Behaviour:
- Reset (async, rst=1): pos_o=0, vel_o=0, busy_o=0, done_o=0, sat_pos_o=0, sat_vel_o=0, state=IDLE, counter=0, latched acc=0, sub=0.
- Saturating add rule: sign-extend both operands to WIDTH+1 and add (subtract in sub mode, computed as a-b in WIDTH+1 bits, never as a+(-b)).
  - Top two bits 01: result = MAX = 2^(WIDTH-1)-1.
  - Top two bits 10: result = MIN = -2^(WIDTH-1).
  - Otherwise: result = low WIDTH bits.
  - A clamp sets the corresponding sticky flag.
- States:
  - IDLE: on step_i=1 (load_i=0), latch acc_i and sub_i, set counter=SUBSTEPS-1, go to VEL.
  - VEL: vel <= sat(vel ± acc_lat); go to POS.
  - POS: pos <= sat(pos + vel), using the vel updated in VEL. If counter==0, go to IDLE and assert done_o next cycle; else counter--, go to VEL.
- Latency: step accepted at edge E. Final pos update at edge E+2*SUBSTEPS. done_o=1 and busy_o=0 during the cycle following that edge.
- done_o is registered and high for exactly one cycle. In that cycle IDLE may already accept a new step.
- step_i while busy: ignored, not queued.
- load_i: accepted in any state. Writes pos/vel and forces IDLE, counter=0, done_o=0. A step in progress is aborted with no done pulse.
- load_i and step_i in the same cycle: load wins, step dropped.
- Sticky flags:
  - Cleared by clr_flags_i, otherwise unaffected by load.
  - clr_flags_i in the same cycle as a new clamp: set wins.
- acc_i/sub_i changes during busy have no effect; the latched values are used.
- Reset asserted mid-operation: immediate return to reset values, no done pulse.

Test Plan:
- WIDTH=17, SUBSTEPS=1: load pos=0, vel=10; step acc=-1, sub=0 -> after 2 cycles vel=9, pos=9; done_o pulses once; flags 0.
- Load pos=65530, vel=10; step acc=0 -> pos=65535 (0x0FFFF), sat_pos_o=1, vel=10. Then clr_flags_i -> sat_pos_o=0.
- Load vel=-65536; step acc=1, sub=1 -> vel=-65536 (0x10000), sat_vel_o=1. Load vel=0; step acc=-65536, sub=1 -> vel=65535, sat_vel_o=1.
- SUBSTEPS=4: load pos=0, vel=0; step acc=2 -> vel=8, pos=2+4+6+8=20; done_o exactly 8 cycles after accept; step_i pulses during busy are ignored.
- Abort cases:
  - Load asserted in POS state mid-step -> new pos/vel loaded, busy_o=0 next cycle, no done_o.
  - Load and step in the same cycle -> load only.
- Reset asserted asynchronously between clock edges while busy -> all outputs 0 immediately; step after release behaves as the first scenario.

Source files
------------

// File: rtl/sat_kinematic_integrator.sv
// Saturating signed kinematic integrator, one instance per axis.
// Each step request runs SUBSTEPS iterations of a velocity update followed
// by a position update. Every add clamps to the signed WIDTH range, and a
// clamp raises a sticky flag that stays set until clr_flags_i.
module sat_kinematic_integrator #(
    parameter int WIDTH    = 17,
    parameter int SUBSTEPS = 1,
    localparam int CNT_W   = $clog2(SUBSTEPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] pos_init_i,
    input  logic [WIDTH-1:0] vel_init_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic             sub_i,
    input  logic             clr_flags_i,
    output logic [WIDTH-1:0] pos_o,
    output logic [WIDTH-1:0] vel_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             sat_pos_o,
    output logic             sat_vel_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VEL  = 2'd1,
        POS  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_lat;
    logic             sub_lat;

    logic [WIDTH:0]   vel_ext;
    logic [WIDTH:0]   pos_ext;
    logic [WIDTH-1:0] vel_next;
    logic [WIDTH-1:0] pos_next;
    logic             vel_clamp;
    logic             pos_clamp;

    // Widened adds with overflow detection on the two top bits; the
    // subtract is done directly so that subtracting MIN clamps correctly.
    always_comb begin
        if (sub_lat) begin
            vel_ext = {vel_o[WIDTH-1], vel_o} - {acc_lat[WIDTH-1], acc_lat};
        end else begin
            vel_ext = {vel_o[WIDTH-1], vel_o} + {acc_lat[WIDTH-1], acc_lat};
        end
        pos_ext = {pos_o[WIDTH-1], pos_o} + {vel_o[WIDTH-1], vel_o};

        vel_next  = vel_ext[WIDTH-1:0];
        vel_clamp = 1'b0;
        case (vel_ext[WIDTH:WIDTH-1])
            2'b01: begin
                vel_next  = MAX_VAL;
                vel_clamp = 1'b1;
            end
            2'b10: begin
                vel_next  = MIN_VAL;
                vel_clamp = 1'b1;
            end
            default: ;
        endcase

        pos_next  = pos_ext[WIDTH-1:0];
        pos_clamp = 1'b0;
        case (pos_ext[WIDTH:WIDTH-1])
            2'b01: begin
                pos_next  = MAX_VAL;
                pos_clamp = 1'b1;
            end
            2'b10: begin
                pos_next  = MIN_VAL;
                pos_clamp = 1'b1;
            end
            default: ;
        endcase
    end

    // Step sequencer: load overrides everything, flag clear loses to a
    // clamp in the same cycle, and done/busy are registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_lat   <= '0;
            sub_lat   <= 1'b0;
            pos_o     <= '0;
            vel_o     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            sat_pos_o <= 1'b0;
            sat_vel_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (clr_flags_i) begin
                sat_pos_o <= 1'b0;
                sat_vel_o <= 1'b0;
            end
            if (load_i) begin
                pos_o  <= pos_init_i;
                vel_o  <= vel_init_i;
                state  <= IDLE;
                cnt    <= '0;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (step_i) begin
                            acc_lat <= acc_i;
                            sub_lat <= sub_i;
                            cnt     <= CNT_W'(SUBSTEPS - 1);
                            state   <= VEL;
                            busy_o  <= 1'b1;
                        end
                    end
                    VEL: begin
                        vel_o <= vel_next;
                        if (vel_clamp) begin
                            sat_vel_o <= 1'b1;
                        end
                        state <= POS;
                    end
                    POS: begin
                        pos_o <= pos_next;
                        if (pos_clamp) begin
                            sat_pos_o <= 1'b1;
                        end
                        if (cnt == '0) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            cnt   <= cnt - CNT_W'(1);
                            state <= VEL;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sat_kinematic_integrator.sv
// Bench for sat_kinematic_integrator: one instance with SUBSTEPS=1 and one
// with SUBSTEPS=4 share load/data/clear inputs but have separate step lines.
// A bench-side integer model predicts results into per-instance queues that
// are popped when the matching done_o pulse appears.
module tb_sat_kinematic_integrator;

    localparam int     W    = 17;
    localparam longint MAXV = 65535;
    localparam longint MINV = -65536;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] pos_init;
    logic [W-1:0] vel_init;
    logic         step1;
    logic         step4;
    logic [W-1:0] acc;
    logic         sub;
    logic         clr;

    logic [W-1:0] pos1, vel1, pos4, vel4;
    logic         busy1, done1, sp1, sv1;
    logic         busy4, done4, sp4, sv4;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] pos;
        logic [W-1:0] vel;
        logic         sp;
        logic         sv;
    } exp_t;

    exp_t   q1[$];
    exp_t   q4[$];
    longint m_pos[2];
    longint m_vel[2];
    bit     m_sp[2];
    bit     m_sv[2];

    sat_kinematic_integrator #(.WIDTH(W), .SUBSTEPS(1)) dut1 (
        .clk(clk), .rst(rst), .load_i(load), .pos_init_i(pos_init),
        .vel_init_i(vel_init), .step_i(step1), .acc_i(acc), .sub_i(sub),
        .clr_flags_i(clr), .pos_o(pos1), .vel_o(vel1), .busy_o(busy1),
        .done_o(done1), .sat_pos_o(sp1), .sat_vel_o(sv1)
    );

    sat_kinematic_integrator #(.WIDTH(W), .SUBSTEPS(4)) dut4 (
        .clk(clk), .rst(rst), .load_i(load), .pos_init_i(pos_init),
        .vel_init_i(vel_init), .step_i(step4), .acc_i(acc), .sub_i(sub),
        .clr_flags_i(clr), .pos_o(pos4), .vel_o(vel4), .busy_o(busy4),
        .done_o(done4), .sat_pos_o(sp4), .sat_vel_o(sv4)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 0;
            m_vel[i] = 0;
            m_sp[i]  = 0;
            m_sv[i]  = 0;
        end
        q1.delete();
        q4.delete();
    endtask

    task automatic model_step(input int idx, input int n, input longint a, input bit s);
        longint v;
        longint p;
        exp_t   e;
        for (int i = 0; i < n; i++) begin
            v = s ? (m_vel[idx] - a) : (m_vel[idx] + a);
            if (v > MAXV) begin v = MAXV; m_sv[idx] = 1; end
            else if (v < MINV) begin v = MINV; m_sv[idx] = 1; end
            m_vel[idx] = v;
            p = m_pos[idx] + v;
            if (p > MAXV) begin p = MAXV; m_sp[idx] = 1; end
            else if (p < MINV) begin p = MINV; m_sp[idx] = 1; end
            m_pos[idx] = p;
        end
        e.pos = W'(m_pos[idx]);
        e.vel = W'(m_vel[idx]);
        e.sp  = m_sp[idx];
        e.sv  = m_sv[idx];
        if (idx == 0) q1.push_back(e);
        else          q4.push_back(e);
    endtask

    task automatic do_load(input longint p, input longint v);
        @(negedge clk);
        load     = 1'b1;
        pos_init = W'(p);
        vel_init = W'(v);
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = p;
            m_vel[i] = v;
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_sp[i] = 0;
            m_sv[i] = 0;
        end
    endtask

    // Returns at the falling edge right after the accepting rising edge (k=1).
    task automatic issue_step(input int idx, input longint a, input bit s);
        @(negedge clk);
        acc = W'(a);
        sub = s;
        if (idx == 0) step1 = 1'b1;
        else          step4 = 1'b1;
        model_step(idx, (idx == 0) ? 1 : 4, a, s);
        @(negedge clk);
        step1 = 1'b0;
        step4 = 1'b0;
    endtask

    // Waits for done, checks its latency in falling edges since accept,
    // pops the expected result and checks the pulse is a single cycle.
    task automatic wait_done(input int idx, input int start_k, input bit poke);
        int     k;
        int     exp_k;
        bit     seen;
        logic   d;
        logic   b;
        exp_t   e;
        k     = start_k;
        exp_k = (idx == 0) ? 3 : 9;
        seen  = 0;
        if (start_k == 1) begin
            b = (idx == 0) ? busy1 : busy4;
            vectors++;
            if (b !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL busy_during_step dut%0d: got %b want 1", idx, b);
            end
        end
        while (k <= 40) begin
            if (poke) step4 = (k == 2 || k == 4 || k == 6);
            d = (idx == 0) ? done1 : done4;
            if (d === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            k++;
        end
        if (poke) step4 = 1'b0;
        vectors++;
        if (!seen || k != exp_k) begin
            miscompares++;
            $display("[TB] FAIL done_latency dut%0d: got %0d (seen=%0b) want %0d", idx, k, seen, exp_k);
        end
        if (!seen) return;
        if ((idx == 0 && q1.size() == 0) || (idx == 1 && q4.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_empty dut%0d: got done want no done", idx);
            return;
        end
        e = (idx == 0) ? q1.pop_front() : q4.pop_front();
        vectors++;
        if (((idx == 0) ? pos1 : pos4) !== e.pos) begin
            miscompares++;
            $display("[TB] FAIL pos dut%0d: got %h want %h", idx, (idx == 0) ? pos1 : pos4, e.pos);
        end
        vectors++;
        if (((idx == 0) ? vel1 : vel4) !== e.vel) begin
            miscompares++;
            $display("[TB] FAIL vel dut%0d: got %h want %h", idx, (idx == 0) ? vel1 : vel4, e.vel);
        end
        vectors++;
        if (((idx == 0) ? sp1 : sp4) !== e.sp) begin
            miscompares++;
            $display("[TB] FAIL sat_pos dut%0d: got %b want %b", idx, (idx == 0) ? sp1 : sp4, e.sp);
        end
        vectors++;
        if (((idx == 0) ? sv1 : sv4) !== e.sv) begin
            miscompares++;
            $display("[TB] FAIL sat_vel dut%0d: got %b want %b", idx, (idx == 0) ? sv1 : sv4, e.sv);
        end
        vectors++;
        if (((idx == 0) ? busy1 : busy4) !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL busy_at_done dut%0d: got 1 want 0", idx);
        end
        @(negedge clk);
        d = (idx == 0) ? done1 : done4;
        b = (idx == 0) ? busy1 : busy4;
        vectors++;
        if (d !== 1'b0 || b !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_single_idle dut%0d: got done=%b busy=%b want 0 0", idx, d, b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 0; step1 = 0; step4 = 0; clr = 0; sub = 0;
        acc = '0; pos_init = '0; vel_init = '0;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({pos1, vel1, busy1, done1, sp1, sv1} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_dut1: got %h/%h/%b%b%b%b want all 0", pos1, vel1, busy1, done1, sp1, sv1);
        end
        vectors++;
        if ({pos4, vel4, busy4, done4, sp4, sv4} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_dut4: got %h/%h/%b%b%b%b want all 0", pos4, vel4, busy4, done4, sp4, sv4);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_load(0, 10);
        issue_step(0, -1, 1'b0);
        wait_done(0, 1, 1'b0);
    endtask

    task automatic test_pos_sat();
        do_load(65530, 10);
        issue_step(0, 0, 1'b0);
        wait_done(0, 1, 1'b0);
        do_clear();
        vectors++;
        if (sp1 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clr_flags: got sat_pos=%b want 0", sp1);
        end
    endtask

    task automatic test_vel_sat();
        do_load(0, -65536);
        issue_step(0, 1, 1'b1);
        wait_done(0, 1, 1'b0);
        do_clear();
        do_load(0, 0);
        issue_step(0, -65536, 1'b1);
        wait_done(0, 1, 1'b0);
    endtask

    task automatic test_clr_vs_set();
        do_clear();
        do_load(65530, 10);
        issue_step(0, 0, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_done(0, 3, 1'b0);
    endtask

    task automatic test_substeps();
        do_load(0, 0);
        issue_step(1, 2, 1'b0);
        wait_done(1, 1, 1'b1);
    endtask

    task automatic test_abort_load();
        bit seen;
        do_load(0, 0);
        @(negedge clk);
        acc = W'(2); sub = 1'b0; step4 = 1'b1;
        @(negedge clk);
        step4 = 1'b0;
        @(negedge clk);
        load = 1'b1; pos_init = W'(100); vel_init = W'(-5);
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 100;
            m_vel[i] = -5;
        end
        vectors++;
        if (pos4 !== W'(100) || vel4 !== W'(-5) || busy4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_load: got %h/%h busy=%b want %h/%h busy=0", pos4, vel4, busy4, W'(100), W'(-5));
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done4 !== 1'b0) seen = 1;
            @(negedge clk);
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done: got done pulse want none");
        end
    endtask

    task automatic test_load_step_same();
        bit bad;
        @(negedge clk);
        load = 1'b1; pos_init = W'(7); vel_init = W'(3);
        step1 = 1'b1; acc = W'(1); sub = 1'b0;
        @(negedge clk);
        load = 1'b0; step1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_pos[i] = 7;
            m_vel[i] = 3;
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy1 !== 1'b0 || done1 !== 1'b0 || pos1 !== W'(7) || vel1 !== W'(3)) bad = 1;
            @(negedge clk);
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL load_beats_step: got pos=%h vel=%h busy=%b want 7/3 idle", pos1, vel1, busy1);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_load(0, 10);
        issue_step(0, -1, 1'b0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({pos1, vel1, busy1, done1, sp1, sv1} !== '0 ||
            {pos4, vel4, busy4, done4, sp4, sv4} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset: got %h/%h/%b and %h/%h/%b want all 0", pos1, vel1, busy1, pos4, vel4, busy4);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done1 !== 1'b0) seen = 1;
            @(negedge clk);
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL reset_no_done: got done pulse want none");
        end
        test_basic();
    endtask

    // Scenario sequence, one summary line at the end.
    initial begin
        test_reset();
        test_basic();
        test_pos_sat();
        test_vel_sat();
        test_clr_vs_set();
        test_substeps();
        test_abort_load();
        test_load_step_same();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
